// File: rtl/pc_flow_ctrl_pkg.sv
// Shared definitions for the fetch-PC / pipeline flow controller:
// debug FSM state encodings, default reset PC, counter width and a helper.
package pc_flow_ctrl_pkg;

    localparam int          CNT_W            = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    // Instruction addresses must be word aligned.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_flow_ctrl_if.sv
// Signal bundle between the flow controller and its neighbours
// (debug port, hazard unit, EX redirect, next_pc_sel, stage registers).
//
// Handshake semantics: this block has no valid/ready pairs. All inputs are
// sampled as levels on every rising clock edge (step is a 1-cycle pulse);
// all outputs are valid for the whole cycle and change only after the edge.
interface pc_flow_ctrl_if;
    import pc_flow_ctrl_pkg::*;

    // debug / hazard / redirect inputs
    logic        run;
    logic        step;
    logic        halt_req;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        load_use;
    logic        redirect;
    logic [31:0] npc;
    logic        cnt_clr;

    // pipeline control and status outputs
    logic [31:0] pc;
    logic        pipe_en;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        halted;
    logic        misalign_err;
    logic [31:0] cyc_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    state_e      dbg_state;

    // the flow controller itself
    modport slave (
        input  run, step, halt_req, bp_en, bp_addr, load_use, redirect, npc, cnt_clr,
        output pc, pipe_en, if_id_stall, if_id_flush, id_ex_flush, halted,
        output misalign_err, cyc_cnt, stall_cnt, flush_cnt, dbg_state
    );

    // the surrounding pipeline / debugger
    modport master (
        output run, step, halt_req, bp_en, bp_addr, load_use, redirect, npc, cnt_clr,
        input  pc, pipe_en, if_id_stall, if_id_flush, id_ex_flush, halted,
        input  misalign_err, cyc_cnt, stall_cnt, flush_cnt, dbg_state
    );

endinterface

// File: rtl/pc_flow_ctrl_perf_cnt.sv
// Wrapping performance counter with synchronous clear (clear beats increment).
module pc_flow_ctrl_perf_cnt
    import pc_flow_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count: clear wins, otherwise count up and wrap naturally
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_flow_ctrl.sv
// Fetch PC owner and pipeline sequencer: commits npc, stalls on load-use,
// flushes on EX redirects and runs the debug HALT/RUN/STEP machine with a
// single PC breakpoint. A breakpoint freezes the hit cycle combinationally;
// the skip flag lets the first cycle after leaving HALT execute past it.
module pc_flow_ctrl
    import pc_flow_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter bit          START_RUN = 1'b0
) (
    input  logic           clk,
    input  logic           rstn,
    pc_flow_ctrl_if.slave  bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        skip_q, skip_d;
    logic        err_q, err_d;

    logic        bp_hit;
    logic        active;
    logic        commit;
    logic        misalign;

    // cycle qualification: breakpoint, activity, commit attempt, alignment
    always_comb begin
        bp_hit   = (state_q == ST_RUN) && bus.bp_en && (pc_q == bus.bp_addr) && !skip_q;
        active   = (state_q != ST_HALT) && !bp_hit && !err_q;
        commit   = active && (bus.redirect || !bus.load_use);
        misalign = commit && !is_aligned(bus.npc);
    end

    // next state for the debug FSM, skip flag, PC and sticky error
    always_comb begin
        state_d = state_q;
        skip_d  = active ? 1'b0 : skip_q;
        pc_d    = (commit && !misalign) ? bus.npc : pc_q;
        err_d   = err_q | misalign;
        case (state_q)
            ST_HALT: begin
                // a latched misalignment error pins the core in HALT
                if (!err_q) begin
                    if (bus.run) begin
                        state_d = ST_RUN;
                        skip_d  = 1'b1;
                    end else if (bus.step) begin
                        state_d = ST_STEP;
                        skip_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.halt_req || bp_hit || misalign) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= START_RUN ? ST_RUN : ST_HALT;
            pc_q    <= RESET_PC;
            skip_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skip_q  <= skip_d;
            err_q   <= err_d;
        end
    end

    // stage-register enables/flushes; everything is quiet when not active
    always_comb begin
        bus.pc           = pc_q;
        bus.pipe_en      = active;
        bus.if_id_stall  = active && bus.load_use && !bus.redirect;
        bus.if_id_flush  = active && bus.redirect;
        bus.id_ex_flush  = active && (bus.redirect || bus.load_use);
        bus.halted       = (state_q == ST_HALT);
        bus.misalign_err = err_q;
        bus.dbg_state    = state_q;
    end

    pc_flow_ctrl_perf_cnt u_cyc_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (bus.cnt_clr),
        .inc_i (active),
        .cnt_o (bus.cyc_cnt)
    );

    pc_flow_ctrl_perf_cnt u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (bus.cnt_clr),
        .inc_i (active && bus.load_use && !bus.redirect),
        .cnt_o (bus.stall_cnt)
    );

    pc_flow_ctrl_perf_cnt u_flush_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (bus.cnt_clr),
        .inc_i (active && bus.redirect),
        .cnt_o (bus.flush_cnt)
    );

endmodule
